cc_poscomparator_scan: RTL and testbench
========================================

# cc_poscomparator_scan

Multi-player, multi-row collision scanner for the game field. Once per frame it walks every row of the field memory, compares each row against every player's column mask in one of two modes, and latches per-player hit flags. From those flags it maintains a saturating lives counter and a game-over flag per player. It sits between the field/row memory and the game-control FSM, and replaces per-player, single-row combinational comparators.

## Interface
Parameters:
- DATAWIDTH, 8, columns per row (row word width)
- ROWS, 8, rows in the field; ROWW = max(1, clog2(ROWS))
- PLAYERS, 2, number of players (comparison lanes)
- LIVES, 3, initial lives per player; LIFEW = clog2(LIVES+1)

Ports:
- CC_POSCOMPARATOR_SCAN_CLOCK_50  in  1  system clock
- CC_POSCOMPARATOR_SCAN_RESET_InLow  in  1  reset, synchronous, active-low
- CC_POSCOMPARATOR_SCAN_start_In  in  1  frame-scan request, one-cycle pulse
- CC_POSCOMPARATOR_SCAN_clear_In  in  1  restore all lives, clear game-over
- CC_POSCOMPARATOR_SCAN_mode_In  in  1  0 = exact equality, 1 = overlap (any common bit)
- CC_POSCOMPARATOR_SCAN_poscol_InBUS  in  PLAYERS*DATAWIDTH  column mask per player; lane i is bits [i*DATAWIDTH +: DATAWIDTH]
- CC_POSCOMPARATOR_SCAN_posrow_InBUS  in  PLAYERS*ROWW  row index per player
- CC_POSCOMPARATOR_SCAN_rowaddr_OutBUS  out  ROWW  field memory row address
- CC_POSCOMPARATOR_SCAN_rowdata_InBUS  in  DATAWIDTH  row word; asynchronous read, valid in the same cycle as the address
- CC_POSCOMPARATOR_SCAN_busy_Out  out  1  scan in progress
- CC_POSCOMPARATOR_SCAN_done_Out  out  1  one-cycle pulse when results are updated
- CC_POSCOMPARATOR_SCAN_hit_OutBUS  out  PLAYERS  hit flags of the last completed frame
- CC_POSCOMPARATOR_SCAN_lives_OutBUS  out  PLAYERS*LIFEW  lives per player
- CC_POSCOMPARATOR_SCAN_gameover_OutBUS  out  PLAYERS  lives reached 0

## Operation
- States and transitions:
  - IDLE → SCAN on start_In. At that edge, poscol, posrow and mode are snapshotted; the per-lane accumulators are cleared.
  - SCAN: rowaddr steps 0..ROWS-1, one row per cycle. Lane i sets its accumulator if both of these hold:
    - rowaddr == posrow[i]
    - mode=0: rowdata == poscol[i]; mode=1: (rowdata & poscol[i]) != 0
  - SCAN → UPDATE after row ROWS-1.
  - UPDATE:
    - hit_OutBUS ← accumulators.
    - For each hit lane with lives > 0, lives decrements by 1. Lives saturate at 0.
    - gameover[i] ← (new lives[i] == 0).
  - UPDATE → DONE. DONE asserts done_Out, then returns to IDLE.
- A lane with poscol == 0 is inactive and never hits, in either mode.
- A lane with posrow ≥ ROWS never hits.
- start_In is ignored outside IDLE. A start in the DONE cycle is lost; a start in the next cycle (IDLE) is accepted.
- clear_In in any state sets every lives to LIVES and gameover to 0; hit_OutBUS is untouched. If clear_In coincides with UPDATE, clear wins for lives and gameover, while hit still updates. An ongoing scan continues.
- A game-over lane still reports hits; its lives stay at 0.
- Input changes during SCAN have no effect (snapshot). rowdata is not snapshotted.

## Timing
- Reset (RESET_InLow = 0 at a clock edge): state IDLE, rowaddr 0, busy 0, done 0, hit all 0, lives all LIVES, gameover all 0. The reset overrides any scan in progress; no partial results are committed.
- Cycle numbering: start sampled at edge 0; SCAN occupies cycles 1..ROWS; UPDATE is cycle ROWS+1; done_Out is high in cycle ROWS+2 only.
- busy_Out is high in cycles 1..ROWS+2.
- hit, lives and gameover change only at the edge ending UPDATE, so they are already stable when done_Out is high.
- rowaddr is 0 outside SCAN.
- Throughput: one frame every ROWS+3 cycles at most.

## Structure
- Package cc_poscomparator_pkg holds:
  - the state encoding constants (IDLE, SCAN, UPDATE, DONE)
  - a clog2 function
  - the MODE_EQ and MODE_OVL constants
- Sub-module cc_poscomparator_lane, instantiated PLAYERS times via generate. Each instance holds one lane's snapshot registers, compare logic, hit accumulator and lives/gameover registers.
- The top level contains the FSM, the row counter and the output bus packing.

## Test plan
- Reset, defaults (DATAWIDTH=8, ROWS=8, PLAYERS=2, LIVES=3) → lives both 3, hit 00, gameover 00, busy 0, rowaddr 0.
- Mode 0, field row 3 = 0x10, P0 at row 3 col 0x10, P1 at row 3 col 0x08, start → done in cycle 10, hit=01, lives P0=2, P1=3.
- Mode 1, row 5 = 0x3C, P1 at row 5 col 0x04, P0 col 0x00 → hit=10, P0 never hits (inactive lane).
- Four consecutive hit frames on P0 → lives 2, 1, 0, 0; gameover[0] is set after the third frame. Then clear_In → lives 3, gameover 0.
- start pulsed again in cycle 4 of a scan → ignored, only one done. poscol changed mid-scan → result uses the snapshot.
- Reset asserted in cycle 5 of a scan → IDLE next cycle, hit and lives unchanged from reset values, no done pulse.

Source files
------------

// File: rtl/cc_poscomparator_pkg.sv
// Shared types and constants for the frame-based collision scanner.
// Holds the scan FSM encoding, compare-mode constants and a clog2 helper.
package cc_poscomparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic MODE_EQ  = 1'b0;
  localparam logic MODE_OVL = 1'b1;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cc_poscomparator_lane.sv
// One player lane: snapshot of position/mode, row compare, hit accumulator,
// and the lives/game-over bookkeeping committed at the end of each frame.
module cc_poscomparator_lane
  import cc_poscomparator_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWS      = 8,
  parameter int ROWW      = 3,
  parameter int LIVES     = 3,
  parameter int LIFEW     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 snap_i,
  input  logic                 scan_i,
  input  logic                 update_i,
  input  logic                 clear_i,
  input  logic                 mode_i,
  input  logic [DATAWIDTH-1:0] poscol_i,
  input  logic [ROWW-1:0]      posrow_i,
  input  logic [ROWW-1:0]      rowaddr_i,
  input  logic [DATAWIDTH-1:0] rowdata_i,
  output logic                 hit_o,
  output logic [LIFEW-1:0]     lives_o,
  output logic                 gameover_o
);

  localparam logic [ROWW:0]      ROWS_EXT   = (ROWW+1)'(ROWS);
  localparam logic [LIFEW-1:0]   LIVES_INIT = LIFEW'(LIVES);
  localparam logic [LIFEW-1:0]   LIFE_ONE   = LIFEW'(1);
  localparam logic [LIFEW-1:0]   LIFE_ZERO  = LIFEW'(0);
  localparam logic [DATAWIDTH-1:0] COL_ZERO = DATAWIDTH'(0);

  logic [DATAWIDTH-1:0] poscol_q, poscol_d;
  logic [ROWW-1:0]      posrow_q, posrow_d;
  logic                 mode_q, mode_d;
  logic                 acc_q, acc_d;
  logic                 hit_q, hit_d;
  logic [LIFEW-1:0]     lives_q, lives_d;
  logic                 gameover_q, gameover_d;

  logic                 col_ok_s;
  logic                 match_s;
  logic [LIFEW-1:0]     lives_dec_s;

  // Compare against the snapshot; an all-zero mask or off-field row never matches.
  always_comb begin
    col_ok_s = 1'b0;
    if (mode_q == MODE_OVL) begin
      col_ok_s = ((rowdata_i & poscol_q) != COL_ZERO);
    end else begin
      col_ok_s = (rowdata_i == poscol_q);
    end
    match_s = scan_i && (poscol_q != COL_ZERO) && ({1'b0, posrow_q} < ROWS_EXT)
              && (rowaddr_i == posrow_q) && col_ok_s;
  end

  always_comb begin
    poscol_d   = poscol_q;
    posrow_d   = posrow_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    hit_d      = hit_q;
    lives_d    = lives_q;
    gameover_d = gameover_q;

    if (snap_i) begin
      poscol_d = poscol_i;
      posrow_d = posrow_i;
      mode_d   = mode_i;
      acc_d    = 1'b0;
    end else if (match_s) begin
      acc_d = 1'b1;
    end else begin
      acc_d = acc_q;
    end

    if (update_i && acc_q && (lives_q != LIFE_ZERO)) begin
      lives_dec_s = lives_q - LIFE_ONE;
    end else begin
      lives_dec_s = lives_q;
    end

    if (update_i) begin
      hit_d = acc_q;
    end else begin
      hit_d = hit_q;
    end

    // Clear takes priority over the end-of-frame lives update.
    if (clear_i) begin
      lives_d    = LIVES_INIT;
      gameover_d = 1'b0;
    end else if (update_i) begin
      lives_d    = lives_dec_s;
      gameover_d = (lives_dec_s == LIFE_ZERO);
    end else begin
      lives_d    = lives_q;
      gameover_d = gameover_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      poscol_q   <= COL_ZERO;
      posrow_q   <= {ROWW{1'b0}};
      mode_q     <= MODE_EQ;
      acc_q      <= 1'b0;
      hit_q      <= 1'b0;
      lives_q    <= LIVES_INIT;
      gameover_q <= 1'b0;
    end else begin
      poscol_q   <= poscol_d;
      posrow_q   <= posrow_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      hit_q      <= hit_d;
      lives_q    <= lives_d;
      gameover_q <= gameover_d;
    end
  end

  assign hit_o      = hit_q;
  assign lives_o    = lives_q;
  assign gameover_o = gameover_q;

endmodule

// File: rtl/cc_poscomparator_scan.sv
// Frame scanner top: walks every field row once per start request, feeds the
// row word to all player lanes and packs their results onto the output buses.
module cc_poscomparator_scan
  import cc_poscomparator_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWS      = 8,
  parameter int PLAYERS   = 2,
  parameter int LIVES     = 3,
  parameter int ROWW      = (clog2(ROWS) < 1) ? 1 : clog2(ROWS),
  parameter int LIFEW     = clog2(LIVES + 1)
) (
  input  logic                         CC_POSCOMPARATOR_SCAN_CLOCK_50,
  input  logic                         CC_POSCOMPARATOR_SCAN_RESET_InLow,
  input  logic                         CC_POSCOMPARATOR_SCAN_start_In,
  input  logic                         CC_POSCOMPARATOR_SCAN_clear_In,
  input  logic                         CC_POSCOMPARATOR_SCAN_mode_In,
  input  logic [PLAYERS*DATAWIDTH-1:0] CC_POSCOMPARATOR_SCAN_poscol_InBUS,
  input  logic [PLAYERS*ROWW-1:0]      CC_POSCOMPARATOR_SCAN_posrow_InBUS,
  output logic [ROWW-1:0]              CC_POSCOMPARATOR_SCAN_rowaddr_OutBUS,
  input  logic [DATAWIDTH-1:0]         CC_POSCOMPARATOR_SCAN_rowdata_InBUS,
  output logic                         CC_POSCOMPARATOR_SCAN_busy_Out,
  output logic                         CC_POSCOMPARATOR_SCAN_done_Out,
  output logic [PLAYERS-1:0]           CC_POSCOMPARATOR_SCAN_hit_OutBUS,
  output logic [PLAYERS*LIFEW-1:0]     CC_POSCOMPARATOR_SCAN_lives_OutBUS,
  output logic [PLAYERS-1:0]           CC_POSCOMPARATOR_SCAN_gameover_OutBUS
);

  localparam logic [ROWW-1:0] LAST_ROW = ROWW'(ROWS - 1);
  localparam logic [ROWW-1:0] ROW_ZERO = ROWW'(0);
  localparam logic [ROWW-1:0] ROW_ONE  = ROWW'(1);

  logic clk;
  logic rst_n;

  state_e          state_q, state_d;
  logic [ROWW-1:0] rowaddr_q, rowaddr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic snap_s;
  logic scan_s;
  logic update_s;

  assign clk   = CC_POSCOMPARATOR_SCAN_CLOCK_50;
  assign rst_n = CC_POSCOMPARATOR_SCAN_RESET_InLow;

  always_comb begin
    state_d   = state_q;
    rowaddr_d = ROW_ZERO;
    case (state_q)
      ST_IDLE: begin
        if (CC_POSCOMPARATOR_SCAN_start_In) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (rowaddr_q == LAST_ROW) begin
          state_d = ST_UPDATE;
        end else begin
          state_d   = ST_SCAN;
          rowaddr_d = rowaddr_q + ROW_ONE;
        end
      end
      ST_UPDATE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rowaddr_q <= ROW_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rowaddr_q <= rowaddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign snap_s   = (state_q == ST_IDLE) && CC_POSCOMPARATOR_SCAN_start_In;
  assign scan_s   = (state_q == ST_SCAN);
  assign update_s = (state_q == ST_UPDATE);

  genvar gi;
  generate
    for (gi = 0; gi < PLAYERS; gi++) begin : g_lane
      cc_poscomparator_lane #(
        .DATAWIDTH (DATAWIDTH),
        .ROWS      (ROWS),
        .ROWW      (ROWW),
        .LIVES     (LIVES),
        .LIFEW     (LIFEW)
      ) u_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .snap_i     (snap_s),
        .scan_i     (scan_s),
        .update_i   (update_s),
        .clear_i    (CC_POSCOMPARATOR_SCAN_clear_In),
        .mode_i     (CC_POSCOMPARATOR_SCAN_mode_In),
        .poscol_i   (CC_POSCOMPARATOR_SCAN_poscol_InBUS[gi*DATAWIDTH +: DATAWIDTH]),
        .posrow_i   (CC_POSCOMPARATOR_SCAN_posrow_InBUS[gi*ROWW +: ROWW]),
        .rowaddr_i  (rowaddr_q),
        .rowdata_i  (CC_POSCOMPARATOR_SCAN_rowdata_InBUS),
        .hit_o      (CC_POSCOMPARATOR_SCAN_hit_OutBUS[gi]),
        .lives_o    (CC_POSCOMPARATOR_SCAN_lives_OutBUS[gi*LIFEW +: LIFEW]),
        .gameover_o (CC_POSCOMPARATOR_SCAN_gameover_OutBUS[gi])
      );
    end
  endgenerate

  assign CC_POSCOMPARATOR_SCAN_rowaddr_OutBUS = rowaddr_q;
  assign CC_POSCOMPARATOR_SCAN_busy_Out       = busy_q;
  assign CC_POSCOMPARATOR_SCAN_done_Out       = done_q;

endmodule

// File: tb/tb_cc_poscomparator_scan.sv
// Self-checking bench: directed frames from the test plan plus random frames,
// compared against a frame-level model of hits, lives and game-over.
module tb_cc_poscomparator_scan;

  localparam int ROWS = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic        mode;
  logic [7:0]  poscol [2];
  logic [2:0]  posrow [2];
  logic [15:0] poscol_bus;
  logic [5:0]  posrow_bus;
  logic [2:0]  rowaddr;
  logic [7:0]  rowdata;
  logic        busy;
  logic        done;
  logic [1:0]  hit;
  logic [3:0]  lives_bus;
  logic [1:0]  gameover;

  logic [7:0]  field [ROWS];
  int          model_lives [2];
  logic [1:0]  model_hit_r;

  int          n_checks;
  int          n_errors;

  assign poscol_bus = {poscol[1], poscol[0]};
  assign posrow_bus = {posrow[1], posrow[0]};
  assign rowdata    = field[rowaddr];

  cc_poscomparator_scan dut (
    .CC_POSCOMPARATOR_SCAN_CLOCK_50        (clk),
    .CC_POSCOMPARATOR_SCAN_RESET_InLow     (rst_n),
    .CC_POSCOMPARATOR_SCAN_start_In        (start),
    .CC_POSCOMPARATOR_SCAN_clear_In        (clear),
    .CC_POSCOMPARATOR_SCAN_mode_In         (mode),
    .CC_POSCOMPARATOR_SCAN_poscol_InBUS    (poscol_bus),
    .CC_POSCOMPARATOR_SCAN_posrow_InBUS    (posrow_bus),
    .CC_POSCOMPARATOR_SCAN_rowaddr_OutBUS  (rowaddr),
    .CC_POSCOMPARATOR_SCAN_rowdata_InBUS   (rowdata),
    .CC_POSCOMPARATOR_SCAN_busy_Out        (busy),
    .CC_POSCOMPARATOR_SCAN_done_Out        (done),
    .CC_POSCOMPARATOR_SCAN_hit_OutBUS      (hit),
    .CC_POSCOMPARATOR_SCAN_lives_OutBUS    (lives_bus),
    .CC_POSCOMPARATOR_SCAN_gameover_OutBUS (gameover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: which lanes see their mask on their own row.
  function automatic logic [1:0] model_hit();
    logic [1:0] h;
    logic [7:0] row;
    for (int i = 0; i < 2; i++) begin
      h[i] = 1'b0;
      if (poscol[i] != 8'd0 && int'(posrow[i]) < ROWS) begin
        row = field[posrow[i]];
        if (mode) h[i] = ((row & poscol[i]) != 8'd0);
        else      h[i] = (row == poscol[i]);
      end
    end
    return h;
  endfunction

  task automatic check_results(input string tag);
    check_eq({tag, "_hit"}, hit, model_hit_r);
    check_eq({tag, "_lives0"}, lives_bus[1:0], model_lives[0]);
    check_eq({tag, "_lives1"}, lives_bus[3:2], model_lives[1]);
    check_eq({tag, "_gameover0"}, gameover[0], (model_lives[0] == 0) ? 1 : 0);
    check_eq({tag, "_gameover1"}, gameover[1], (model_lives[1] == 0) ? 1 : 0);
  endtask

  // disturb: 0 none, 1 restart pulse + mask change in cycle 4, 2 clear during UPDATE
  task automatic run_frame(input string tag, input int disturb);
    logic [1:0] exp_hit;
    int done_cycle;
    int extra_done;
    exp_hit = model_hit();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    done_cycle = -1;
    for (int c = 1; c <= 20; c++) begin
      check_eq({tag, "_rowaddr"}, rowaddr, (c <= ROWS) ? c - 1 : 0);
      check_eq({tag, "_busy"}, busy, 1);
      start = (disturb == 1 && c == 4);
      if (disturb == 1 && c == 4) begin
        poscol[0] = ~poscol[0];
        poscol[1] = ~poscol[1];
      end
      clear = (disturb == 2 && c == ROWS + 1);
      if (done) begin
        done_cycle = c;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    clear = 1'b0;
    check_eq({tag, "_done_cycle"}, done_cycle, ROWS + 2);
    model_hit_r = exp_hit;
    for (int i = 0; i < 2; i++) begin
      if (exp_hit[i] && model_lives[i] > 0) model_lives[i] = model_lives[i] - 1;
      if (disturb == 2) model_lives[i] = 3;
    end
    check_results(tag);
    if (disturb == 1) begin
      extra_done = 0;
      for (int c = 0; c < ROWS + 4; c++) begin
        @(negedge clk);
        if (done || busy) extra_done = extra_done + 1;
      end
      check_eq({tag, "_no_second_frame"}, extra_done, 0);
    end
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_lives[0] = 3;
    model_lives[1] = 3;
    check_results(tag);
  endtask

  task automatic setup_eq_frame();
    for (int r = 0; r < ROWS; r++) field[r] = 8'h00;
    field[3]  = 8'h10;
    mode      = 1'b0;
    poscol[0] = 8'h10; posrow[0] = 3'd3;
    poscol[1] = 8'h08; posrow[1] = 3'd3;
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; mode = 1'b0;
    poscol[0] = 8'h00; poscol[1] = 8'h00; posrow[0] = 3'd0; posrow[1] = 3'd0;
    for (int r = 0; r < ROWS; r++) field[r] = 8'h00;
    model_lives[0] = 3; model_lives[1] = 3; model_hit_r = 2'b00;

    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_rowaddr", rowaddr, 0);
    check_results("reset");
    rst_n = 1'b1;

    setup_eq_frame();
    run_frame("eq_frame", 0);
    check_eq("eq_frame_hit_const", hit, 2'b01);
    check_eq("eq_frame_lives_const", lives_bus, {2'd3, 2'd2});

    for (int r = 0; r < ROWS; r++) field[r] = 8'h00;
    field[5]  = 8'h3C;
    mode      = 1'b1;
    poscol[0] = 8'h00; posrow[0] = 3'd5;
    poscol[1] = 8'h04; posrow[1] = 3'd5;
    run_frame("ovl_frame", 0);
    check_eq("ovl_frame_hit_const", hit, 2'b10);

    do_clear("clear1");
    setup_eq_frame();
    for (int k = 0; k < 4; k++) begin
      run_frame("p0_repeat", 0);
      check_eq("p0_repeat_lives_const", lives_bus[1:0], (k < 3) ? 2 - k : 0);
      check_eq("p0_repeat_gameover_const", gameover[0], (k >= 2) ? 1 : 0);
    end
    do_clear("clear2");

    setup_eq_frame();
    run_frame("restart_ignored", 1);
    setup_eq_frame();
    run_frame("clear_in_update", 2);

    for (int f = 0; f < 24; f++) begin
      if (f % 6 == 5) do_clear("rnd_clear");
      mode = 1'($urandom_range(0, 1));
      for (int r = 0; r < ROWS; r++) field[r] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 2; i++) begin
        poscol[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        posrow[i] = 3'($urandom_range(0, ROWS - 1));
        if ($urandom_range(0, 1) == 1) field[posrow[i]] = poscol[i];
      end
      run_frame("rnd", int'($urandom_range(0, 2)));
    end

    setup_eq_frame();
    run_frame("pre_reset", 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_lives[0] = 3; model_lives[1] = 3; model_hit_r = 2'b00;
    check_eq("midreset_busy", busy, 0);
    check_eq("midreset_rowaddr", rowaddr, 0);
    check_results("midreset");
    seen = 0;
    for (int c = 0; c < ROWS + 4; c++) begin
      @(negedge clk);
      if (done || busy) seen = seen + 1;
    end
    check_eq("midreset_no_done", seen, 0);
    check_results("midreset_hold");

    setup_eq_frame();
    run_frame("post_reset", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
